// File: rtl/jtag_dmi_bridge.sv
// jtag_dmi_bridge: JTAG TAP oversampled in ext_clk, turning DMI DR updates into req/ack debug-bus transactions
module jtag_dmi_bridge #(
    parameter logic [31:0] IDCODE    = 32'h0A5C_0001,
    parameter int          DMI_ABITS = 8
) (
    input  logic                 ext_clk,
    input  logic                 ext_rst,
    input  logic                 jtag_tck,
    input  logic                 jtag_tms,
    input  logic                 jtag_tdi,
    input  logic                 jtag_trst,
    output logic                 jtag_tdo,
    output logic [DMI_ABITS-1:0] dmi_addr,
    output logic [63:0]          dmi_din,
    input  logic [63:0]          dmi_dout,
    output logic                 dmi_req,
    output logic                 dmi_wr,
    input  logic                 dmi_ack
);
    localparam int DRW = DMI_ABITS + 66;
    localparam logic [5:0] IR_IDCODE = 6'h09;
    localparam logic [5:0] IR_DMI    = 6'h22;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_e;

    tap_e                 state_q, state_d, tap_nxt;
    logic [1:0]           tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic                 tck_prev_q;
    logic [5:0]           ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DRW-1:0]       dr_q, dr_d;
    logic                 tdo_q, tdo_d, req_q, req_d, wr_q, wr_d;
    logic [DMI_ABITS-1:0] addr_q, addr_d;
    logic [63:0]          din_q, din_d, rsp_q, rsp_d;
    logic                 rise, fall, tms, tdi, tap_rst, sel_idcode, sel_dmi;
    logic [1:0]           op;

    assign tms        = tms_sync_q[1];
    assign tdi        = tdi_sync_q[1];
    assign rise       = tck_sync_q[1] & ~tck_prev_q;
    assign fall       = ~tck_sync_q[1] & tck_prev_q;
    assign tap_rst    = ~ext_rst | ~trst_sync_q[1];
    assign sel_idcode = ir_q == IR_IDCODE;
    assign sel_dmi    = ir_q == IR_DMI;
    assign op         = dr_q[1:0];

    assign jtag_tdo = tdo_q;
    assign dmi_req  = req_q;
    assign dmi_wr   = wr_q;
    assign dmi_addr = addr_q;
    assign dmi_din  = din_q;

    always_comb begin
        case (state_q)
            TLR:     tap_nxt = tms ? TLR    : RTI;
            RTI:     tap_nxt = tms ? SEL_DR : RTI;
            SEL_DR:  tap_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_nxt = tms ? UPD_DR : PA_DR;
            PA_DR:   tap_nxt = tms ? EX2_DR : PA_DR;
            EX2_DR:  tap_nxt = tms ? UPD_DR : SH_DR;
            SEL_IR:  tap_nxt = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_nxt = tms ? UPD_IR : PA_IR;
            PA_IR:   tap_nxt = tms ? EX2_IR : PA_IR;
            EX2_IR:  tap_nxt = tms ? UPD_IR : SH_IR;
            default: tap_nxt = tms ? SEL_DR : RTI;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ir_sr_d = ir_sr_q;
        dr_d    = dr_q;
        tdo_d   = tdo_q;
        req_d   = req_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rsp_d   = rsp_q;
        if (rise) begin
            state_d = tap_nxt;
            case (state_q)
                CAP_IR: ir_sr_d = 6'b000001;
                SH_IR:  ir_sr_d = {tdi, ir_sr_q[5:1]};
                UPD_IR: ir_d = ir_sr_q;
                CAP_DR: dr_d = sel_dmi ? {addr_q, rsp_q, {2{req_q}}} : sel_idcode ? DRW'(IDCODE) : '0;
                SH_DR:  dr_d = sel_dmi ? {tdi, dr_q[DRW-1:1]} : sel_idcode ? DRW'({tdi, dr_q[31:1]}) : DRW'(tdi);
                UPD_DR: begin
                    // An op arriving while a request is outstanding is dropped, not queued
                    if (sel_dmi && !req_q && (op == 2'd1 || op == 2'd2)) begin
                        req_d  = 1'b1;
                        wr_d   = op == 2'd2;
                        addr_d = dr_q[DRW-1:66];
                        din_d  = dr_q[65:2];
                    end
                end
                default: ;
            endcase
        end
        if (state_q == TLR) ir_d = IR_IDCODE;
        if (fall) tdo_d = state_q == SH_IR ? ir_sr_q[0] : state_q == SH_DR ? dr_q[0] : 1'b0;
        if (req_q && dmi_ack) begin
            req_d = 1'b0;
            rsp_d = wr_q ? din_q : dmi_dout;
        end
    end

    always_ff @(posedge ext_clk) begin
        if (!ext_rst) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
            tck_prev_q  <= 1'b0;
        end else begin
            tck_sync_q  <= {tck_sync_q[0], jtag_tck};
            tms_sync_q  <= {tms_sync_q[0], jtag_tms};
            tdi_sync_q  <= {tdi_sync_q[0], jtag_tdi};
            trst_sync_q <= {trst_sync_q[0], jtag_trst};
            tck_prev_q  <= tck_sync_q[1];
        end
        if (tap_rst) begin
            state_q <= TLR;
            ir_q    <= IR_IDCODE;
            ir_sr_q <= '0;
            dr_q    <= '0;
            tdo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ir_sr_q <= ir_sr_d;
            dr_q    <= dr_d;
            tdo_q   <= tdo_d;
        end
        if (!ext_rst) begin
            req_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            rsp_q  <= '0;
        end else begin
            req_q  <= req_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            rsp_q  <= rsp_d;
        end
    end
endmodule

// File: tb/tb_jtag_dmi_bridge.sv
// tb_jtag_dmi_bridge: randomized JTAG/DMI stimulus checked against a transaction-level model
module tb_jtag_dmi_bridge;
    localparam logic [31:0] IDC = 32'h0A5C_0001;

    logic        ext_clk = 0, ext_rst = 0, jtag_tck = 0, jtag_tms = 1, jtag_tdi = 0, jtag_trst = 1;
    logic        jtag_tdo, dmi_req, dmi_wr, dmi_ack = 0;
    logic [7:0]  dmi_addr;
    logic [63:0] dmi_din, dmi_dout = '0;
    int          total = 0, passed = 0;

    // Transaction model: last accepted request, response register, outstanding flag
    logic [7:0]  m_addr = '0;
    logic [63:0] m_din = '0, m_rsp = '0;
    logic        m_wr = 0, m_busy = 0;

    always #5 ext_clk = ~ext_clk;

    jtag_dmi_bridge dut (
        .ext_clk(ext_clk), .ext_rst(ext_rst), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
        .jtag_tdi(jtag_tdi), .jtag_trst(jtag_trst), .jtag_tdo(jtag_tdo), .dmi_addr(dmi_addr),
        .dmi_din(dmi_din), .dmi_dout(dmi_dout), .dmi_req(dmi_req), .dmi_wr(dmi_wr), .dmi_ack(dmi_ack)
    );

    task automatic clk(input int n);
        repeat (n) @(posedge ext_clk);
        #1;
    endtask

    task automatic bit_io(input logic tms, input logic tdi, output logic tdo);
        jtag_tms = tms;
        jtag_tdi = tdi;
        clk(8);
        tdo = jtag_tdo;
        jtag_tck = 1;
        clk(8);
        jtag_tck = 0;
    endtask

    task automatic walk(input logic [7:0] tms, input int n);
        logic t;
        for (int i = 0; i < n; i++) bit_io(tms[i], 1'b0, t);
    endtask

    task automatic shift_ir(input logic [5:0] v, output logic [5:0] o);
        logic t;
        walk(8'b0011, 4);
        for (int i = 0; i < 6; i++) begin bit_io(i == 5, v[i], t); o[i] = t; end
        walk(8'b01, 2);
    endtask

    task automatic shift_dr(input int n, input logic [73:0] v, output logic [73:0] o);
        logic t;
        o = '0;
        walk(8'b001, 3);
        for (int i = 0; i < n; i++) begin bit_io(i == n - 1, v[i], t); o[i] = t; end
        walk(8'b01, 2);
    endtask

    // A length-len register captured with cap emits cap first, then the bits shifted in
    function automatic logic [73:0] exp_shift(input int len, input logic [73:0] cap, input logic [73:0] din, input int n);
        logic [73:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            if (i < len) r[i] = cap[i];
            else r[i] = din[i-len];
        return r;
    endfunction

    task automatic dmi_op(input logic [1:0] op, input logic [7:0] a, input logic [63:0] d);
        logic [73:0] o, e;
        e = {m_addr, m_rsp, m_busy ? 2'b11 : 2'b00};
        shift_dr(74, {a, d, op}, o);
        if ((op == 2'd1 || op == 2'd2) && !m_busy) begin
            m_busy = 1; m_wr = op == 2'd2; m_addr = a; m_din = d;
        end
        total++;
        if (o !== e) $display("FAIL dmi_capture op=%0d got %h want %h", op, o, e);
        else passed++;
        total++;
        if ({dmi_req, dmi_addr, dmi_din} !== {m_busy, m_addr, m_din} || (m_busy && dmi_wr !== m_wr))
            $display("FAIL dmi_bus req/wr/addr/din got %b/%b/%h/%h want %b/%b/%h/%h",
                     dmi_req, dmi_wr, dmi_addr, dmi_din, m_busy, m_wr, m_addr, m_din);
        else passed++;
    endtask

    task automatic do_ack(input logic [63:0] d);
        dmi_dout = d;
        dmi_ack = 1;
        clk(1);
        dmi_ack = 0;
        if (m_busy) begin m_rsp = m_wr ? m_din : d; m_busy = 0; end
        total++;
        if (dmi_req !== 1'b0) $display("FAIL ack_drop req got %b want 0", dmi_req);
        else passed++;
    endtask

    task automatic test_reset;
        ext_rst = 0;
        clk(5);
        total++;
        if ({jtag_tdo, dmi_req, dmi_wr, dmi_addr, dmi_din} !== '0)
            $display("FAIL reset tdo/req/wr/addr/din got %b/%b/%b/%h/%h want all 0", jtag_tdo, dmi_req, dmi_wr, dmi_addr, dmi_din);
        else passed++;
        ext_rst = 1;
        clk(4);
    endtask

    task automatic test_idcode;
        logic [73:0] v, o, e;
        v = {$urandom, $urandom, $urandom};
        walk(8'b0, 1);
        shift_dr(40, v, o);
        e = exp_shift(32, 74'(IDC), v, 40);
        total++;
        if (o !== e) $display("FAIL idcode got %h want %h", o, e);
        else passed++;
    endtask

    task automatic test_bypass;
        logic [5:0] ir_o, ir;
        logic [73:0] v, o, e;
        for (int k = 0; k < 3; k++) begin
            ir = k == 0 ? 6'h3F : k == 1 ? 6'h15 : 6'($urandom_range(0, 63));
            while (ir == 6'h09 || ir == 6'h22) ir = 6'($urandom_range(0, 63));
            shift_ir(ir, ir_o);
            total++;
            if (ir_o !== 6'b000001) $display("FAIL ir_capture got %b want 000001", ir_o);
            else passed++;
            v = k == 2 ? 74'($urandom_range(0, 255)) : 74'hA5;
            shift_dr(8, v, o);
            e = exp_shift(1, '0, v, 8);
            total++;
            if (o !== e) $display("FAIL bypass ir=%h got %h want %h", ir, o, e);
            else passed++;
        end
    endtask

    task automatic test_dmi_write;
        logic [5:0] ir_o;
        shift_ir(6'h22, ir_o);
        dmi_op(2'd2, 8'h10, 64'h1122334455667788);
        clk(5);
        total++;
        if ({dmi_req, dmi_wr} !== 2'b11) $display("FAIL write_hold req/wr got %b%b want 11", dmi_req, dmi_wr);
        else passed++;
        do_ack({$urandom, $urandom});
    endtask

    task automatic test_dmi_read;
        dmi_op(2'd1, 8'h11, {$urandom, $urandom});
        clk($urandom_range(0, 4));
        do_ack(64'hDEADBEEFCAFEF00D);
        do_ack({$urandom, $urandom});
        dmi_op(2'd0, 8'($urandom), {$urandom, $urandom});
    endtask

    task automatic test_outstanding;
        logic [7:0] a1;
        a1 = 8'($urandom_range(0, 31));
        dmi_op(2'd2, a1, {$urandom, $urandom});
        dmi_op(2'd2, 8'h20, {$urandom, $urandom});
        total++;
        if (dmi_addr !== a1) $display("FAIL dropped_write addr got %h want %h", dmi_addr, a1);
        else passed++;
        dmi_op(2'd0, 8'($urandom), '0);
        do_ack({$urandom, $urandom});
        dmi_op(2'd0, 8'($urandom), '0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            dmi_op(2'($urandom_range(0, 3)), 8'($urandom), {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) begin
                clk($urandom_range(0, 4));
                do_ack({$urandom, $urandom});
            end
        end
        do_ack({$urandom, $urandom});
    endtask

    task automatic test_trst;
        logic [5:0] ir_o;
        logic [73:0] v, o;
        logic t;
        v = {8'h33, $urandom, $urandom, 2'b10};
        walk(8'b001, 3);
        for (int i = 0; i < 40; i++) bit_io(1'b0, v[i], t);
        jtag_trst = 0;
        clk(6);
        total++;
        if (jtag_tdo !== 1'b0) $display("FAIL trst_tdo got %b want 0", jtag_tdo);
        else passed++;
        jtag_trst = 1;
        clk(6);
        walk(8'b0, 1);
        shift_dr(32, '0, o);
        total++;
        if (o !== 74'(IDC) || dmi_req !== 1'b0) $display("FAIL trst_idcode got %h req %b want %h req 0", o, dmi_req, IDC);
        else passed++;
        shift_ir(6'h22, ir_o);
    endtask

    task automatic test_ext_rst;
        logic [5:0] ir_o;
        dmi_op(2'd1, 8'($urandom), {$urandom, $urandom});
        ext_rst = 0;
        clk(1);
        total++;
        if (dmi_req !== 1'b0) $display("FAIL ext_rst_req got %b want 0", dmi_req);
        else passed++;
        clk(3);
        ext_rst = 1;
        m_addr = '0; m_din = '0; m_rsp = '0; m_busy = 0; m_wr = 0;
        clk(4);
        total++;
        if ({dmi_req, dmi_wr, dmi_addr, dmi_din} !== '0)
            $display("FAIL ext_rst_bus req/wr/addr/din got %b/%b/%h/%h want all 0", dmi_req, dmi_wr, dmi_addr, dmi_din);
        else passed++;
        walk(8'b0, 1);
        shift_ir(6'h22, ir_o);
        dmi_op(2'd0, 8'($urandom), '0);
    endtask

    initial begin
        test_reset;
        test_idcode;
        test_bypass;
        test_dmi_write;
        test_dmi_read;
        test_outstanding;
        test_random;
        test_trst;
        test_ext_rst;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/jtag_dmi_bridge.md
# jtag_dmi_bridge

Synchronous JTAG TAP and debug-module-interface (DMI) bridge that sits between the JTAG pads (tck/tms/tdi/trst in, tdo out) and the microwatt core's debug bus. It oversamples the JTAG pins in the system clock domain, runs a standard IEEE 1149.1 TAP state machine with IDCODE, BYPASS and DMI instructions, and converts DMI-register updates into single request/acknowledge read or write transactions toward the core's debug module.

## Interface
Parameters:
- IDCODE, 32'h0A5C_0001, value shifted out by the IDCODE instruction; bit 0 must be 1.
- DMI_ABITS, 8, DMI address width.

Ports:
- ext_clk  in  1  system clock, one clock domain for the whole block.
- ext_rst  in  1  reset, synchronous, active-low.
- jtag_tck  in  1  raw JTAG clock pin, asynchronous.
- jtag_tms  in  1  raw JTAG mode select, asynchronous.
- jtag_tdi  in  1  raw JTAG data in, asynchronous.
- jtag_trst  in  1  raw JTAG reset, active-low, asynchronous.
- jtag_tdo  out  1  JTAG data out.
- dmi_addr  out  DMI_ABITS  debug register address.
- dmi_din  out  64  write data toward the core.
- dmi_dout  in  64  read data from the core.
- dmi_req  out  1  transaction request, held until ack.
- dmi_wr  out  1  1 = write, 0 = read; valid while dmi_req is high.
- dmi_ack  in  1  transaction complete; sampled only while dmi_req is high.

## Operation
- tck, tms, tdi and trst each pass through a 2-flop synchronizer. A rise event is registered tck_s=1 with previous 0; a fall event is tck_s=0 with previous 1.
- Synchronized trst low or ext_rst low forces the TAP to Test-Logic-Reset, IR to IDCODE, and jtag_tdo to 0. trst does not affect the DMI handshake; only ext_rst does.
- TAP: 16 standard states, advancing on rise events only, with next state selected by synchronized tms. Five tms=1 rises from any state reach Test-Logic-Reset.
- IR is 6 bits. Instructions:
  - 6'h09 IDCODE.
  - 6'h22 DMI.
  - 6'h3F BYPASS.
  - Any other value selects BYPASS.
- Capture-IR loads 6'b000001.
- Update-IR commits the shifted value. Test-Logic-Reset sets IR to IDCODE.
- DRs shift LSB-first. On a rise in Shift-xR, tdi enters the MSB and the LSB leaves.
  - IDCODE DR: 32 bits, loads IDCODE at Capture-DR.
  - BYPASS DR: 1 bit, loads 0 at Capture-DR.
  - DMI DR: 74 bits, laid out as {addr[73:66], data[65:2], op[1:0]}.
- DMI Capture-DR loads {last_addr, rsp_data, status}:
  - status is 2'b11 while a request is outstanding, otherwise 2'b00.
  - rsp_data holds the most recent read result, or the write data if the last transaction was a write.
- DMI Update-DR acts on op:
  - op=1 (read) or op=2 (write) with no request outstanding: latch dmi_addr and dmi_din, set dmi_wr=(op==2), and assert dmi_req.
  - op=0 or op=3: no action.
  - A read or write while a request is outstanding is dropped; no queue.
- Handshake:
  - dmi_req stays high until a cycle with dmi_ack=1. The next cycle dmi_req=0.
  - On a read ack, rsp_data is loaded from dmi_dout in the ack cycle.
  - dmi_ack while dmi_req is low is ignored.
- jtag_tdo updates on fall events only. It drives the LSB of the selected register in Shift-IR or Shift-DR, and 0 in every other state.
- Reset values: jtag_tdo=0, dmi_req=0, dmi_wr=0, dmi_addr=0, dmi_din=0, rsp_data=0, IR=IDCODE, TAP=Test-Logic-Reset.

## Timing
- Pin to event: a tck edge is recognized 3 ext_clk cycles after the pin transition (2 synchronizer cycles plus 1 edge cycle).
- State, shift, capture and update registers change in the cycle after the rise event.
- jtag_tdo changes one cycle after the fall event.
- ext_clk must be at least 6x TCK. tms and tdi must be stable from 3 cycles before the tck rise.
- dmi_req rises 1 cycle after the rise event that leaves Update-DR. Minimum transaction is 2 cycles (req, ack, req low).
- Update-DR and ack in the same cycle: the ack completes the old transaction; the new op is dropped because a request was outstanding when it was evaluated.
- ext_rst low mid-transaction: dmi_req drops in the next cycle, with no ack wait.
- trst low mid-shift: the shift is abandoned, IR returns to IDCODE, and no Update occurs.

## Test plan
- Reset then walk to Shift-DR (tms 0,1,0,0) and shift 32 bits: tdo returns 0x0A5C0001 LSB-first.
- Load IR 6'h3F and shift 8 bits 0xA5 through DR: tdo echoes 0xA5 delayed by exactly one tck. Repeat with IR 6'h15 and get the same result.
- Load IR 6'h22 and shift {addr 0x10, data 0x1122334455667788, op 2}: dmi_req=1, dmi_wr=1, dmi_addr=0x10, dmi_din=0x1122334455667788. Ack after 5 cycles drops req one cycle later.
- DMI read of addr 0x11 with dmi_dout=0xDEADBEEFCAFEF00D and ack: the next DMI capture with op=0 shifts out addr 0x11, data 0xDEADBEEFCAFEF00D, status 00.
- Hold ack low, then issue a second write to addr 0x20: dmi_addr stays at the first address, and capture reports status 11. Assert ack and the next capture reports 00.
- Pulse trst low during DMI Shift-DR: no dmi_req, TAP returns to Test-Logic-Reset, and a following DR shift returns IDCODE.
